// File: rtl/accel_trig_pkg.sv
// Shared types and default parameters for the accelerator trigger.
package accel_trig_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } trig_state_t;

    localparam int TRIG_CNT_W   = 4;
    localparam int TRIG_TO_W    = 16;
    localparam int TRIG_TIMEOUT = 1024;

endpackage

// File: rtl/accel_trigger_if.sv
// Event, handshake and status bundle between the timer side and the trigger.
interface accel_trigger_if #(
    parameter int CNT_W = accel_trig_pkg::TRIG_CNT_W,
    parameter int TO_W  = accel_trig_pkg::TRIG_TO_W
);

    logic             pulse_in;
    logic             clr;
    logic             ack;
    logic             req;
    logic             busy;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             timeout;
    logic [TO_W-1:0]  last_latency;

    modport master (
        output pulse_in, clr, ack,
        input  req, busy, pending, overflow, timeout, last_latency
    );

    modport slave (
        input  pulse_in, clr, ack,
        output req, busy, pending, overflow, timeout, last_latency
    );

endinterface

// File: rtl/pulse_edge_det.sv
// Registered rising-edge detector; a level high out of reset counts as an edge.
module pulse_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse,
    output logic pulse_edge
);

    logic pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_d <= 1'b0;
        end else begin
            pulse_d <= pulse;
        end
    end

    assign pulse_edge = pulse & ~pulse_d;

endmodule

// File: rtl/accel_trigger.sv
// Turns timer pulses into queued four-phase req/ack handshakes with a watchdog.
module accel_trigger
    import accel_trig_pkg::*;
#(
    parameter int CNT_W   = TRIG_CNT_W,
    parameter int TO_W    = TRIG_TO_W,
    parameter int TIMEOUT = TRIG_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    accel_trigger_if.slave  bus
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [TO_W-1:0]  CNT_MAX  = '1;
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);

    trig_state_t      state_q, state_d;
    logic             req_q, req_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             to_q, to_d;
    logic [TO_W-1:0]  lat_q, lat_d;
    logic             rise;
    logic             launch;

    pulse_edge_det u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulse      (bus.pulse_in),
        .pulse_edge (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        to_d    = to_q;
        lat_d   = lat_q;
        launch  = 1'b0;
        if (bus.clr) begin
            state_d = IDLE;
            req_d   = 1'b0;
            pend_d  = '0;
            ovf_d   = 1'b0;
            to_d    = 1'b0;
            lat_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if ((pend_q != '0 || rise) && !bus.ack) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        cnt_d   = TO_W'(1);
                        launch  = 1'b1;
                    end
                end
                REQ: begin
                    // ack wins over an expiring watchdog on the same edge
                    if (bus.ack) begin
                        state_d = REL;
                        req_d   = 1'b0;
                        lat_d   = cnt_q;
                    end else if (cnt_q == TO_LIM) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        to_d    = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + TO_W'(1);
                    end
                end
                REL: begin
                    if (!bus.ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
            if (rise && !launch) begin
                if (pend_q == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + CNT_W'(1);
                end
            end else if (!rise && launch) begin
                pend_d = pend_q - CNT_W'(1);
            end
        end
    end

    assign bus.req          = req_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.pending      = pend_q;
    assign bus.overflow     = ovf_q;
    assign bus.timeout      = to_q;
    assign bus.last_latency = lat_q;

endmodule

// File: tb/tb_accel_trigger.sv
// Directed bench for accel_trigger: one DUT with a long watchdog, one with TIMEOUT=8.
module tb_accel_trigger;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    accel_trigger_if #(.CNT_W(4), .TO_W(16)) bus_a ();
    accel_trigger_if #(.CNT_W(4), .TO_W(16)) bus_w ();

    accel_trigger #(.CNT_W(4), .TO_W(16), .TIMEOUT(1024)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    accel_trigger #(.CNT_W(4), .TO_W(16), .TIMEOUT(8)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    function automatic logic [23:0] outs_a();
        return {bus_a.req, bus_a.busy, bus_a.pending, bus_a.overflow,
                bus_a.timeout, bus_a.last_latency};
    endfunction

    function automatic logic [23:0] outs_w();
        return {bus_w.req, bus_w.busy, bus_w.pending, bus_w.overflow,
                bus_w.timeout, bus_w.last_latency};
    endfunction

    task automatic test_reset();
        #12;
        total++;
        if (outs_a() !== 24'h0)
            $display("FAIL reset_a got %h want 000000", outs_a());
        else passed++;
        total++;
        if (outs_w() !== 24'h0)
            $display("FAIL reset_w got %h want 000000", outs_w());
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (outs_a() !== 24'h0)
            $display("FAIL post_reset_a got %h want 000000", outs_a());
        else passed++;
    endtask

    task automatic test_single();
        for (int i = 0; i < 10; i++) begin
            bus_a.pulse_in = (i == 0);
            bus_a.ack      = (i == 5 || i == 6);
            @(negedge clk);
            total++;
            if (bus_a.req !== (i + 1 <= 5))
                $display("FAIL single_req k=%0d got %b want %b", i + 1, bus_a.req, (i + 1 <= 5));
            else passed++;
            total++;
            if (bus_a.busy !== (i + 1 <= 7))
                $display("FAIL single_busy k=%0d got %b want %b", i + 1, bus_a.busy, (i + 1 <= 7));
            else passed++;
            total++;
            if (bus_a.pending !== 4'd0)
                $display("FAIL single_pending k=%0d got %0d want 0", i + 1, bus_a.pending);
            else passed++;
        end
        total++;
        if (bus_a.last_latency !== 16'd5)
            $display("FAIL single_latency got %0d want 5", bus_a.last_latency);
        else passed++;
    endtask

    task automatic test_burst();
        int         peak  = 0;
        int         rises = 0;
        logic       prev  = 1'b0;
        logic [3:0] at_rise [4];
        for (int i = 0; i < 4; i++) at_rise[i] = 4'hx;
        for (int i = 0; i < 45; i++) begin
            bus_a.pulse_in = (i == 0 || i == 2 || i == 4 || i == 6);
            bus_a.ack      = (i >= 21) && bus_a.req;
            @(negedge clk);
            if (int'(bus_a.pending) > peak) peak = int'(bus_a.pending);
            if (bus_a.req && !prev) begin
                if (rises < 4) at_rise[rises] = bus_a.pending;
                rises++;
            end
            prev = bus_a.req;
            if (i == 21) begin
                total++;
                if (bus_a.last_latency !== 16'd21)
                    $display("FAIL burst_first_latency got %0d want 21", bus_a.last_latency);
                else passed++;
            end
        end
        bus_a.ack = 1'b0;
        total++;
        if (peak !== 3) $display("FAIL burst_peak got %0d want 3", peak);
        else passed++;
        total++;
        if (rises !== 4) $display("FAIL burst_rises got %0d want 4", rises);
        else passed++;
        total++;
        if (at_rise[1] !== 4'd2 || at_rise[2] !== 4'd1 || at_rise[3] !== 4'd0)
            $display("FAIL burst_drain got %0d,%0d,%0d want 2,1,0", at_rise[1], at_rise[2], at_rise[3]);
        else passed++;
        total++;
        if (bus_a.last_latency !== 16'd1)
            $display("FAIL burst_last_latency got %0d want 1", bus_a.last_latency);
        else passed++;
        total++;
        if (bus_a.busy !== 1'b0 || bus_a.pending !== 4'd0)
            $display("FAIL burst_idle got busy=%b pend=%0d want 0/0", bus_a.busy, bus_a.pending);
        else passed++;
    endtask

    task automatic test_overflow();
        int   rises = 0;
        logic prev  = 1'b0;
        bus_a.clr = 1'b1;
        @(negedge clk);
        bus_a.clr = 1'b0;
        for (int i = 0; i < 34; i++) begin
            bus_a.pulse_in = (i % 2 == 0);
            bus_a.ack      = 1'b0;
            @(negedge clk);
            if (bus_a.req && !prev) rises++;
            prev = bus_a.req;
            if (i + 1 == 31) begin
                total++;
                if (bus_a.pending !== 4'd15 || bus_a.overflow !== 1'b0)
                    $display("FAIL ovf_16th got pend=%0d ovf=%b want 15/0", bus_a.pending, bus_a.overflow);
                else passed++;
            end
            if (i + 1 == 33) begin
                total++;
                if (bus_a.pending !== 4'd15 || bus_a.overflow !== 1'b1)
                    $display("FAIL ovf_17th got pend=%0d ovf=%b want 15/1", bus_a.pending, bus_a.overflow);
                else passed++;
            end
        end
        total++;
        if (rises !== 1 || bus_a.req !== 1'b1)
            $display("FAIL ovf_in_flight got rises=%0d req=%b want 1/1", rises, bus_a.req);
        else passed++;
        bus_a.clr = 1'b1;
        @(negedge clk);
        bus_a.clr = 1'b0;
        total++;
        if (outs_a() !== 24'h0)
            $display("FAIL ovf_clr got %h want 000000", outs_a());
        else passed++;
    endtask

    task automatic test_watchdog();
        int hi = 0;
        for (int i = 0; i < 12; i++) begin
            bus_w.pulse_in = (i == 0);
            bus_w.ack      = 1'b0;
            @(negedge clk);
            if (bus_w.req) hi++;
            if (i + 1 == 8) begin
                total++;
                if (bus_w.req !== 1'b1 || bus_w.timeout !== 1'b0)
                    $display("FAIL wd_k8 got req=%b to=%b want 1/0", bus_w.req, bus_w.timeout);
                else passed++;
            end
            if (i + 1 == 9) begin
                total++;
                if (bus_w.req !== 1'b0 || bus_w.timeout !== 1'b1 || bus_w.busy !== 1'b0)
                    $display("FAIL wd_k9 got req=%b to=%b busy=%b want 0/1/0",
                             bus_w.req, bus_w.timeout, bus_w.busy);
                else passed++;
            end
        end
        total++;
        if (hi !== 8) $display("FAIL wd_req_cycles got %0d want 8", hi);
        else passed++;
        bus_w.clr = 1'b1;
        @(negedge clk);
        bus_w.clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus_w.pulse_in = (i == 0);
            bus_w.ack      = (i == 8);
            @(negedge clk);
            if (i + 1 == 9) begin
                total++;
                if (bus_w.req !== 1'b0 || bus_w.busy !== 1'b1 ||
                    bus_w.timeout !== 1'b0 || bus_w.last_latency !== 16'd8)
                    $display("FAIL wd_edge got req=%b busy=%b to=%b lat=%0d want 0/1/0/8",
                             bus_w.req, bus_w.busy, bus_w.timeout, bus_w.last_latency);
                else passed++;
            end
        end
        total++;
        if (bus_w.timeout !== 1'b0 || bus_w.busy !== 1'b0)
            $display("FAIL wd_edge_end got to=%b busy=%b want 0/0", bus_w.timeout, bus_w.busy);
        else passed++;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 13; i++) begin
            bus_a.pulse_in = (i == 0 || i == 2 || i == 4 || i == 8);
            bus_a.ack      = (i >= 6 && i <= 10);
            bus_a.clr      = (i == 6);
            @(negedge clk);
            if (i + 1 == 6) begin
                total++;
                if (bus_a.req !== 1'b1 || bus_a.pending !== 4'd2)
                    $display("FAIL clr_pre got req=%b pend=%0d want 1/2", bus_a.req, bus_a.pending);
                else passed++;
            end
            if (i + 1 == 7) begin
                total++;
                if (bus_a.req !== 1'b0 || bus_a.pending !== 4'd0 || bus_a.busy !== 1'b0)
                    $display("FAIL clr_post got req=%b pend=%0d busy=%b want 0/0/0",
                             bus_a.req, bus_a.pending, bus_a.busy);
                else passed++;
            end
            if (i + 1 >= 8 && i + 1 <= 11) begin
                total++;
                if (bus_a.req !== 1'b0)
                    $display("FAIL clr_wait_ack k=%0d got req=%b want 0", i + 1, bus_a.req);
                else passed++;
            end
            if (i + 1 == 9) begin
                total++;
                if (bus_a.pending !== 4'd1)
                    $display("FAIL clr_queued got %0d want 1", bus_a.pending);
                else passed++;
            end
            if (i + 1 == 12) begin
                total++;
                if (bus_a.req !== 1'b1 || bus_a.pending !== 4'd0)
                    $display("FAIL clr_relaunch got req=%b pend=%0d want 1/0", bus_a.req, bus_a.pending);
                else passed++;
            end
        end
        bus_a.pulse_in = 1'b0;
        bus_a.ack      = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   rises = 0;
        logic prev  = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus_w.pulse_in = (i == 0 || i == 10);
            bus_w.ack      = 1'b0;
            @(negedge clk);
        end
        total++;
        if (bus_w.req !== 1'b1 || bus_w.timeout !== 1'b1)
            $display("FAIL rst_setup got req=%b to=%b want 1/1", bus_w.req, bus_w.timeout);
        else passed++;
        bus_w.pulse_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (outs_w() !== 24'h0)
            $display("FAIL rst_async_w got %h want 000000", outs_w());
        else passed++;
        total++;
        if (outs_a() !== 24'h0)
            $display("FAIL rst_async_a got %h want 000000", outs_a());
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus_w.req && !prev) rises++;
            prev = bus_w.req;
            if (j == 0) begin
                total++;
                if (bus_w.req !== 1'b1)
                    $display("FAIL rst_held_launch got req=%b want 1", bus_w.req);
                else passed++;
            end
            total++;
            if (bus_w.pending !== 4'd0)
                $display("FAIL rst_pending j=%0d got %0d want 0", j, bus_w.pending);
            else passed++;
        end
        total++;
        if (rises !== 1) $display("FAIL rst_one_request got %0d want 1", rises);
        else passed++;
        bus_w.pulse_in = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_a.pulse_in = 1'b0;
        bus_a.clr      = 1'b0;
        bus_a.ack      = 1'b0;
        bus_w.pulse_in = 1'b0;
        bus_w.clr      = 1'b0;
        bus_w.ack      = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_watchdog();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
